// File: rtl/msx_psg_pkg.sv
// msx_psg_pkg -- shared constants for the MSX1 PSG (AY-3-8910 compatible).
// Holds register indices, per-register read/write masks, mixer and
// envelope-shape bit positions, the LFSR seed and the DAC transfer function.
// Optional build macro: PSG_LOG_DAC_EN selects the logarithmic DAC table,
// otherwise the DAC is linear (amp * 17).
package msx_psg_pkg;

    // Register indices
    localparam logic [3:0] R_TONE_A_F  = 4'd0;
    localparam logic [3:0] R_TONE_A_C  = 4'd1;
    localparam logic [3:0] R_TONE_B_F  = 4'd2;
    localparam logic [3:0] R_TONE_B_C  = 4'd3;
    localparam logic [3:0] R_TONE_C_F  = 4'd4;
    localparam logic [3:0] R_TONE_C_C  = 4'd5;
    localparam logic [3:0] R_NOISE     = 4'd6;
    localparam logic [3:0] R_MIXER     = 4'd7;
    localparam logic [3:0] R_VOL_A     = 4'd8;
    localparam logic [3:0] R_VOL_B     = 4'd9;
    localparam logic [3:0] R_VOL_C     = 4'd10;
    localparam logic [3:0] R_ENV_F     = 4'd11;
    localparam logic [3:0] R_ENV_C     = 4'd12;
    localparam logic [3:0] R_ENV_SHAPE = 4'd13;
    localparam logic [3:0] R_IOA       = 4'd14;
    localparam logic [3:0] R_IOB       = 4'd15;

    // Implemented bits per register, index 15 leftmost.
    localparam logic [15:0][7:0] REG_MASK = {
        8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'hFF, 8'h1F, 8'h1F, 8'h1F,
        8'hFF, 8'h1F, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 8'h0F, 8'hFF
    };

    // R7 bit positions: tone disable A/B/C at 0..2, noise disable at 3..5.
    localparam int MIX_TONE_A  = 0;
    localparam int MIX_NOISE_A = 3;
    localparam int MIX_IOB_OUT = 7;

    // Volume register: bit 4 selects the envelope as amplitude source.
    localparam int VOL_ENV_BIT = 4;

    // Envelope shape bits (R13).
    localparam int SHAPE_HOLD = 0;
    localparam int SHAPE_ALT  = 1;
    localparam int SHAPE_ATT  = 2;
    localparam int SHAPE_CONT = 3;

    localparam logic [16:0] LFSR_SEED = 17'h00001;

    // Roughly 3 dB per step, index 15 leftmost.
    localparam logic [15:0][7:0] LOG_DAC = {
        8'd255, 8'd181, 8'd128, 8'd90, 8'd64, 8'd45, 8'd32, 8'd23,
        8'd16,  8'd11,  8'd8,   8'd6,  8'd4,  8'd3,  8'd2,  8'd0
    };

    function automatic logic [7:0] dac(input logic [3:0] amp);
`ifdef PSG_LOG_DAC_EN
        return LOG_DAC[amp];
`else
        // amp * 17 == amp * 16 + amp
        return {amp, amp};
`endif
    endfunction

endpackage

// File: rtl/msx_psg_envelope.sv
// msx_psg_envelope -- shared AY envelope generator.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   tick       : prescaled advance strobe
//   period     : 16-bit envelope period {R12, R11}; 0 behaves as 1
//   shape      : R13 shape bits {CONT, ATT, ALT, HOLD}
//   restart    : pulse on an R13 write; restarts the ramp
//   level      : current 4-bit envelope level
import msx_psg_pkg::*;

module msx_psg_envelope (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic [15:0] period,
    input  logic [3:0]  shape,
    input  logic        restart,
    output logic [3:0]  level
);

    logic [15:0] cnt;
    logic [3:0]  step;
    logic        hold;
    logic        invert;   // ALT toggles this instead of rewriting shape
    logic        mute;     // CONT = 0 forces the level to zero after one ramp
    logic [15:0] per_eff;
    logic        att;

    assign per_eff = (period == 16'd0) ? 16'd1 : period;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            step   <= '0;
            hold   <= 1'b0;
            invert <= 1'b0;
            mute   <= 1'b0;
        end else if (restart) begin
            cnt    <= '0;
            step   <= '0;
            hold   <= 1'b0;
            invert <= 1'b0;
            mute   <= 1'b0;
        end else if (tick && !hold) begin
            if ({1'b0, cnt} + 17'd1 >= {1'b0, per_eff}) begin
                cnt <= '0;
                if (step == 4'd15) begin
                    if (!shape[SHAPE_CONT]) begin
                        hold <= 1'b1;
                        mute <= 1'b1;
                    end else if (shape[SHAPE_HOLD]) begin
                        // Freeze on step 15; ALT flips to the opposite end.
                        hold <= 1'b1;
                        if (shape[SHAPE_ALT]) invert <= ~invert;
                    end else begin
                        step <= 4'd0;
                        if (shape[SHAPE_ALT]) invert <= ~invert;
                    end
                end else begin
                    step <= step + 4'd1;
                end
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    // ATT is read live from R13 so a restart picks up the new shape at once.
    assign att   = shape[SHAPE_ATT] ^ invert;
    assign level = mute ? 4'd0 : (att ? step : ~step);

endmodule

// File: rtl/msx_psg.sv
// msx_psg -- AY-3-8910 compatible PSG for the MSX1 core.
// Three tone channels, one noise LFSR, a shared envelope, GPIO port A input
// and port B output latch, and a registered unsigned mix of the channels.
// Ports:
//   clk_i, reset_n_i      : system clock, asynchronous active-low reset
//   ce_3m58_i             : 3.58 MHz clock enable; generators step every 16
//   cs_n_i, rd_n_i, wr_n_i: bus strobes from the I/O decoder / CPU
//   addr_i                : 0 latch, 1 data write, 2 data read, 3 ignored
//   d_i, d_o              : CPU write / read data (d_o = FFh when idle)
//   ioa_i, iob_o          : GPIO port A input, port B output
//   audio_o               : sum of the three channel levels
// Build macro: PSG_LOG_DAC_EN (logarithmic DAC; linear when undefined).
import msx_psg_pkg::*;

module msx_psg #(
    parameter int AUDIO_W = 10
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               ce_3m58_i,
    input  logic               cs_n_i,
    input  logic               rd_n_i,
    input  logic               wr_n_i,
    input  logic [1:0]         addr_i,
    input  logic [7:0]         d_i,
    output logic [7:0]         d_o,
    input  logic [7:0]         ioa_i,
    output logic [7:0]         iob_o,
    output logic [AUDIO_W-1:0] audio_o
);

    function automatic logic [11:0] nz12(input logic [11:0] p);
        return (p == 12'd0) ? 12'd1 : p;
    endfunction

    logic [7:0]  regs [16];
    logic [3:0]  latch;
    logic        latch_ok;
    logic        strobe_n;
    logic        strobe_q;
    logic        wr_fire;
    logic        env_restart;

    // ---------------- bus writes: one action per strobe falling edge
    assign strobe_n    = cs_n_i | wr_n_i;
    assign wr_fire     = strobe_q & ~strobe_n;
    assign env_restart = wr_fire && (addr_i == 2'd1) && latch_ok
                         && (latch == R_ENV_SHAPE);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            strobe_q <= 1'b1;
            latch    <= '0;
            latch_ok <= 1'b1;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            strobe_q <= strobe_n;
            if (wr_fire) begin
                case (addr_i)
                    2'd0: begin
                        latch    <= d_i[3:0];
                        latch_ok <= (d_i[7:4] == 4'd0);
                    end
                    2'd1: if (latch_ok) regs[latch] <= d_i & REG_MASK[latch];
                    default: ;
                endcase
            end
        end
    end

    // ---------------- bus reads (combinational)
    always_comb begin
        d_o = 8'hFF;
        if (!cs_n_i && !rd_n_i && addr_i == 2'd2 && latch_ok) begin
            d_o = (latch == R_IOA) ? ioa_i : (regs[latch] & REG_MASK[latch]);
        end
    end

    assign iob_o = regs[R_MIXER][MIX_IOB_OUT] ? regs[R_IOB] : 8'h00;

    // ---------------- prescaler: tick on every 16th enable
    logic [3:0] pre;
    logic       tick;

    assign tick = ce_3m58_i && (pre == 4'hF);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)     pre <= '0;
        else if (ce_3m58_i) pre <= pre + 4'd1;
    end

    // ---------------- tone channels
    logic [11:0] tone_per [3];
    logic [11:0] tone_cnt [3];
    logic [2:0]  tone_out;

    always_comb begin
        tone_per[0] = nz12({regs[R_TONE_A_C][3:0], regs[R_TONE_A_F]});
        tone_per[1] = nz12({regs[R_TONE_B_C][3:0], regs[R_TONE_B_F]});
        tone_per[2] = nz12({regs[R_TONE_C_C][3:0], regs[R_TONE_C_F]});
    end

    // The >= compare makes a period shrunk below the running count
    // expire on the very next tick instead of wrapping through 4095.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int ch = 0; ch < 3; ch++) tone_cnt[ch] <= '0;
            tone_out <= '0;
        end else if (tick) begin
            for (int ch = 0; ch < 3; ch++) begin
                if ({1'b0, tone_cnt[ch]} + 13'd1 >= {1'b0, tone_per[ch]}) begin
                    tone_cnt[ch] <= '0;
                    tone_out[ch] <= ~tone_out[ch];
                end else begin
                    tone_cnt[ch] <= tone_cnt[ch] + 12'd1;
                end
            end
        end
    end

    // ---------------- noise: half-rate counter driving a 17-bit LFSR
    logic        noise_half;
    logic [4:0]  noise_cnt;
    logic [4:0]  noise_per;
    logic [16:0] lfsr;
    logic        noise;

    assign noise_per = (regs[R_NOISE][4:0] == 5'd0) ? 5'd1 : regs[R_NOISE][4:0];
    assign noise     = lfsr[0];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            noise_half <= 1'b0;
            noise_cnt  <= '0;
            lfsr       <= LFSR_SEED;
        end else if (tick) begin
            noise_half <= ~noise_half;
            if (noise_half) begin
                if ({1'b0, noise_cnt} + 6'd1 >= {1'b0, noise_per}) begin
                    noise_cnt <= '0;
                    lfsr      <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
                end else begin
                    noise_cnt <= noise_cnt + 5'd1;
                end
            end
        end
    end

    // ---------------- envelope
    logic [3:0] env_level;

    msx_psg_envelope u_envelope (
        .clk     (clk_i),
        .rst_n   (reset_n_i),
        .tick    (tick),
        .period  ({regs[R_ENV_C], regs[R_ENV_F]}),
        .shape   (regs[R_ENV_SHAPE][3:0]),
        .restart (env_restart),
        .level   (env_level)
    );

    // ---------------- mixer and DAC
    logic [4:0] vol [3];
    logic [3:0] amp [3];
    logic [7:0] lvl [3];

    always_comb begin
        vol[0] = regs[R_VOL_A][4:0];
        vol[1] = regs[R_VOL_B][4:0];
        vol[2] = regs[R_VOL_C][4:0];
        for (int ch = 0; ch < 3; ch++) begin
            amp[ch] = vol[ch][VOL_ENV_BIT] ? env_level : vol[ch][3:0];
            // A disabled source reads as 1, so both disabled gives DC.
            lvl[ch] = ((tone_out[ch] | regs[R_MIXER][MIX_TONE_A + ch]) &
                       (noise | regs[R_MIXER][MIX_NOISE_A + ch]))
                      ? dac(amp[ch]) : 8'd0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) audio_o <= '0;
        else            audio_o <= AUDIO_W'(lvl[0]) + AUDIO_W'(lvl[1]) + AUDIO_W'(lvl[2]);
    end

endmodule

// File: tb/tb_msx_psg.sv
// tb_msx_psg -- directed bench for msx_psg: bus access, tone timing, noise
// sequence against a reference LFSR, envelope ramps/hold and async reset.
module tb_msx_psg;

    localparam int AUDIO_W = 10;

    logic               clk     = 1'b0;
    logic               reset_n = 1'b0;
    logic               ce      = 1'b0;
    logic               cs_n    = 1'b1;
    logic               rd_n    = 1'b1;
    logic               wr_n    = 1'b1;
    logic [1:0]         addr    = 2'd0;
    logic [7:0]         d_in    = 8'h00;
    logic [7:0]         ioa     = 8'h00;
    logic [7:0]         d_out;
    logic [7:0]         iob;
    logic [AUDIO_W-1:0] audio;

    int n_vec  = 0;
    int n_miss = 0;

    msx_psg #(.AUDIO_W(AUDIO_W)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .ce_3m58_i (ce),
        .cs_n_i    (cs_n),
        .rd_n_i    (rd_n),
        .wr_n_i    (wr_n),
        .addr_i    (addr),
        .d_i       (d_in),
        .d_o       (d_out),
        .ioa_i     (ioa),
        .iob_o     (iob),
        .audio_o   (audio)
    );

    // ---------------- clock / enable / watchdog
    always #5 clk = ~clk;

    // Enable on every second clock: one tick = 16 enables = 32 clocks.
    initial forever begin
        @(negedge clk);
        ce = ~ce;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference helpers
    function automatic logic [15:0] dac_m(input int a);
`ifdef PSG_LOG_DAC_EN
        case (a)
            0: return 16'd0;    1: return 16'd2;    2: return 16'd3;    3: return 16'd4;
            4: return 16'd6;    5: return 16'd8;    6: return 16'd11;   7: return 16'd16;
            8: return 16'd23;   9: return 16'd32;   10: return 16'd45;  11: return 16'd64;
            12: return 16'd90;  13: return 16'd128; 14: return 16'd181; default: return 16'd255;
        endcase
`else
        return 16'(a * 17);
`endif
    endfunction

    // ---------------- checking
    task automatic check_vec(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers
    task automatic bus_write(input logic [1:0] a, input logic [7:0] v);
        @(negedge clk);
        addr = a; d_in = v; cs_n = 1'b0; wr_n = 1'b0;
        @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic write_reg(input logic [7:0] r, input logic [7:0] v);
        bus_write(2'd0, r);
        bus_write(2'd1, v);
    endtask

    task automatic read_reg(input logic [7:0] r, output logic [7:0] v);
        bus_write(2'd0, r);
        @(negedge clk);
        addr = 2'd2; cs_n = 1'b0; rd_n = 1'b0;
        #1 v = d_out;
        @(negedge clk);
        cs_n = 1'b1; rd_n = 1'b1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Waits (at negedges) for audio to change; n = negedges waited.
    task automatic wait_change(input int limit, output int n,
                               output logic [AUDIO_W-1:0] v, output bit seen);
        logic [AUDIO_W-1:0] prev;
        prev = audio; n = 0; seen = 1'b0; v = audio;
        while (!seen && n < limit) begin
            @(negedge clk);
            n++;
            if (audio != prev) begin
                seen = 1'b1;
                v    = audio;
            end
        end
    endtask

    // ---------------- stimulus
    logic [7:0]         rv;
    logic [AUDIO_W-1:0] v1, v2;
    int                 n1, n2;
    bit                 s1, s2;
    logic [16:0]        lfsr_m;
    logic               e_bits [32];

    task automatic tone_interval(input string tag, input int exp_clks);
        wait_change(200, n1, v1, s1);
        wait_change(200, n1, v1, s1);
        wait_change(200, n1, v1, s1);
        wait_change(200, n2, v2, s2);
        check_vec({tag, "_seen"}, 16'({s1, s2}), 16'd3);
        check_vec({tag, "_half1"}, 16'(n1), 16'(exp_clks));
        check_vec({tag, "_half2"}, 16'(n2), 16'(exp_clks));
        check_vec({tag, "_lvl"}, 16'(v1 == 0 || 16'(v1) == dac_m(15)), 16'd1);
        check_vec({tag, "_alt"}, 16'(v1) + 16'(v2), dac_m(15));
    endtask

    initial begin
        // reference noise bits: bit0 of the LFSR after j shifts
        lfsr_m = 17'h00001;
        for (int j = 0; j < 32; j++) begin
            e_bits[j] = lfsr_m[0];
            lfsr_m    = {lfsr_m[0] ^ lfsr_m[3], lfsr_m[16:1]};
        end

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // ---- reset state
        check_vec("rst_audio", 16'(audio), 16'd0);
        check_vec("rst_iob", 16'(iob), 16'd0);
        check_vec("rst_dout_idle", 16'(d_out), 16'hFF);
        read_reg(8'h00, rv);
        check_vec("rst_r0", 16'(rv), 16'h00);

        // ---- register access and masks
        write_reg(8'h07, 8'h38);
        read_reg(8'h07, rv);  check_vec("r7_rw", 16'(rv), 16'h38);
        write_reg(8'h01, 8'hFF);
        read_reg(8'h01, rv);  check_vec("r1_mask", 16'(rv), 16'h0F);
        write_reg(8'h06, 8'hFF);
        read_reg(8'h06, rv);  check_vec("r6_mask", 16'(rv), 16'h1F);
        write_reg(8'h0D, 8'hFF);
        read_reg(8'h0D, rv);  check_vec("r13_mask", 16'(rv), 16'h0F);
        read_reg(8'h1F, rv);  check_vec("bad_latch_rd", 16'(rv), 16'hFF);
        bus_write(2'd1, 8'hAA);  // latch still invalid: must be dropped
        read_reg(8'h0F, rv);  check_vec("bad_latch_wr", 16'(rv), 16'h00);

        // ---- GPIO
        write_reg(8'h0F, 8'hA5);
        read_reg(8'h0F, rv);  check_vec("r15_rd", 16'(rv), 16'hA5);
        check_vec("iob_off", 16'(iob), 16'h00);
        write_reg(8'h07, 8'hB8);
        check_vec("iob_on", 16'(iob), 16'hA5);
        write_reg(8'h07, 8'h78);
        check_vec("iob_r7b6", 16'(iob), 16'h00);
        ioa = 8'h5A;
        read_reg(8'h0E, rv);  check_vec("r14_ioa", 16'(rv), 16'h5A);

        // ---- tone A, period 1 / 0 / 2
        write_reg(8'h00, 8'h01);
        write_reg(8'h01, 8'h00);
        write_reg(8'h08, 8'h0F);
        write_reg(8'h07, 8'h3E);
        tone_interval("tone_p1", 32);
        write_reg(8'h00, 8'h00);
        tone_interval("tone_p0", 32);
        write_reg(8'h00, 8'h02);
        tone_interval("tone_p2", 64);

        // ---- noise on A, tone B (period 1) on B as a per-tick marker
        pulse_reset();
        write_reg(8'h07, 8'h35);
        write_reg(8'h09, 8'h01);
        write_reg(8'h08, 8'h0F);
        check_vec("noise_pre", 16'(audio), dac_m(15));
        for (int k = 1; k <= 60; k++) begin
            wait_change(100, n1, v1, s1);
            check_vec("noise_seen", 16'(s1), 16'd1);
            check_vec($sformatf("noise_t%0d", k), 16'(v1),
                      (e_bits[k/2] ? dac_m(15) : 16'd0) + ((k % 2) ? dac_m(1) : 16'd0));
        end

        // ---- envelope: sawtooth up, repeat
        pulse_reset();
        write_reg(8'h07, 8'hBF);
        write_reg(8'h0F, 8'hA5);
        write_reg(8'h08, 8'h10);
        write_reg(8'h0B, 8'h01);
        write_reg(8'h0C, 8'h00);
        write_reg(8'h0D, 8'h0C);
        check_vec("env_up_start", 16'(audio), 16'd0);
        check_vec("env_iob", 16'(iob), 16'hA5);
        for (int k = 1; k <= 17; k++) begin
            wait_change(100, n1, v1, s1);
            check_vec("env_up_seen", 16'(s1), 16'd1);
            check_vec($sformatf("env_up_%0d", k), 16'(v1), dac_m(k % 16));
            if (k > 1) check_vec("env_up_rate", 16'(n1), 16'd32);
        end

        // ---- envelope: single ramp down, then hold at 0
        write_reg(8'h0D, 8'h09);
        check_vec("env_dn_start", 16'(audio), dac_m(15));
        for (int k = 14; k >= 0; k--) begin
            wait_change(100, n1, v1, s1);
            check_vec("env_dn_seen", 16'(s1), 16'd1);
            check_vec($sformatf("env_dn_%0d", k), 16'(v1), dac_m(k));
        end
        wait_change(200, n1, v1, s1);
        check_vec("env_hold_still", 16'(s1), 16'd0);
        check_vec("env_hold_lvl", 16'(audio), 16'd0);

        // ---- mid-envelope asynchronous reset
        write_reg(8'h0D, 8'h0C);
        for (int k = 0; k < 3; k++) wait_change(100, n1, v1, s1);
        check_vec("mid_env_lvl", 16'(audio), dac_m(3));
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_vec("arst_audio", 16'(audio), 16'd0);
        check_vec("arst_iob", 16'(iob), 16'd0);
        check_vec("arst_dout", 16'(d_out), 16'hFF);
        @(negedge clk);
        reset_n = 1'b1;
        read_reg(8'h0D, rv);  check_vec("arst_r13", 16'(rv), 16'h00);
        read_reg(8'h07, rv);  check_vec("arst_r7", 16'(rv), 16'h00);
        check_vec("arst_audio_after", 16'(audio), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
